// File: rtl/draw_pkg.sv
// Shared widths, arbiter state encoding and the one-hot helper for the
// draw-port arbiter slice.
package draw_pkg;

   localparam int X_W   = 8;
   localparam int Y_W   = 7;
   localparam int COL_W = 3;
   localparam int MAX_N = 8;

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_GRANT   = 2'd1,
      S_RELEASE = 2'd2
   } state_t;

   // Wide enough for the largest supported requester count; callers truncate.
   function automatic logic [MAX_N-1:0] onehot(input logic [2:0] idx);
      onehot = MAX_N'(1) << idx;
   endfunction

endpackage

// File: rtl/draw_port_arbiter_rr_pick.sv
// Combinational round-robin selector: first set request bit at or after ptr,
// wrapping modulo N.
module rr_pick #(
   parameter int N     = 4,
   parameter int PTR_W = 2
) (
   input  logic [N-1:0]     req,
   input  logic [PTR_W-1:0] ptr,
   output logic [PTR_W-1:0] sel,
   output logic             any
);

   logic [N-1:0] rot;
   int           pos;

   // Rotate so that bit 0 is the requester under the pointer.
   assign rot = N'({req, req} >> ptr);

   always_comb begin
      sel = '0;
      any = 1'b0;
      pos = 0;
      for (int k = 0; k < N; k++) begin
         if (!any && rot[k]) begin
            any = 1'b1;
            pos = int'(ptr) + k;
            if (pos >= N) pos = pos - N;
            sel = PTR_W'(pos);
         end
      end
   end

endmodule

// File: rtl/draw_port_arbiter.sv
// Round-robin owner of the VGA plot port: one requester holds the port for a
// whole burst, pixels are registered, and a watchdog reclaims stalled bursts.
module draw_port_arbiter
   import draw_pkg::*;
#(
   parameter int N         = 4,
   parameter int PTR_W     = 2,
   parameter int MAX_STALL = 1023,
   parameter int STALL_W   = 10
) (
   input  logic               clk,
   input  logic               resetn,
   input  logic [N-1:0]       req,
   input  logic [N-1:0]       pix_valid,
   input  logic [N-1:0]       done,
   input  logic [X_W*N-1:0]   x_in,
   input  logic [Y_W*N-1:0]   y_in,
   input  logic [COL_W*N-1:0] col_in,
   output logic [N-1:0]       gnt,
   output logic               draw_enable,
   output logic [X_W-1:0]     x_out,
   output logic [Y_W-1:0]     y_out,
   output logic [COL_W-1:0]   col_out,
   output logic               busy,
   output logic               stall_err
);

   state_t               state, state_d;
   logic [PTR_W-1:0]     ptr;
   logic [PTR_W-1:0]     owner;
   logic [PTR_W-1:0]     sel;
   logic                 any;
   logic [STALL_W-1:0]   stall_cnt;

   logic                 own_req, own_pix, own_done;
   logic                 stall_hit, leave, force_rel, fwd;
   logic [X_W-1:0]       x_sel;
   logic [Y_W-1:0]       y_sel;
   logic [COL_W-1:0]     col_sel;

   rr_pick #(
      .N     (N),
      .PTR_W (PTR_W)
   ) u_pick (
      .req (req),
      .ptr (ptr),
      .sel (sel),
      .any (any)
   );

   always_comb begin
      own_req  = req[owner];
      own_pix  = pix_valid[owner];
      own_done = done[owner];
      x_sel    = x_in[int'(owner)*X_W +: X_W];
      y_sel    = y_in[int'(owner)*Y_W +: Y_W];
      col_sel  = col_in[int'(owner)*COL_W +: COL_W];
   end

   // A stall fires on the MAX_STALL-th consecutive granted cycle without a pixel.
   assign stall_hit = !own_pix && (stall_cnt == STALL_W'(MAX_STALL - 1));
   assign fwd       = (state == S_GRANT) && own_pix;
   assign busy      = (state == S_GRANT) || (state == S_RELEASE);

   always_comb begin
      state_d   = state;
      leave     = 1'b0;
      force_rel = 1'b0;
      case (state)
         S_IDLE: begin
            if (any) state_d = S_GRANT;
         end
         S_GRANT: begin
            // done outranks an abandoned request, which outranks the watchdog.
            if (own_done || !own_req) begin
               leave = 1'b1;
            end else if (stall_hit) begin
               leave     = 1'b1;
               force_rel = 1'b1;
            end
            if (leave) state_d = S_RELEASE;
         end
         S_RELEASE: state_d = S_IDLE;
         default:   state_d = S_IDLE;
      endcase
   end

   // Stage boundary: control registers (state, ownership, pointer, watchdog)
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state     <= S_IDLE;
         owner     <= '0;
         ptr       <= '0;
         gnt       <= '0;
         stall_cnt <= '0;
         stall_err <= 1'b0;
      end else begin
         state <= state_d;
         case (state)
            S_IDLE: begin
               if (any) begin
                  owner     <= sel;
                  gnt       <= N'(onehot(3'(sel)));
                  stall_cnt <= '0;
               end
            end
            S_GRANT: begin
               if (own_pix) stall_cnt <= '0;
               else         stall_cnt <= stall_cnt + STALL_W'(1);
               if (leave) begin
                  gnt <= '0;
                  ptr <= (owner == PTR_W'(N - 1)) ? '0 : owner + PTR_W'(1);
               end
               if (force_rel) stall_err <= 1'b1;
            end
            default: ;
         endcase
      end
   end

   // Stage boundary: registered pixel path to the VGA adapter
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         draw_enable <= 1'b0;
         x_out       <= '0;
         y_out       <= '0;
         col_out     <= '0;
      end else begin
         draw_enable <= fwd;
         if (fwd) begin
            x_out   <= x_sel;
            y_out   <= y_sel;
            col_out <= col_sel;
         end
      end
   end

endmodule

// File: tb/tb_draw_port_arbiter.sv
// Scoreboard bench for draw_port_arbiter: directed bursts push expected pixels
// and grant owners; a negedge monitor pops and compares.
module tb_draw_port_arbiter;

   localparam int N         = 4;
   localparam int PTR_W     = 2;
   localparam int MAX_STALL = 1023;
   localparam int STALL_W   = 10;

   logic             clk = 1'b0;
   logic             resetn = 1'b0;
   logic [N-1:0]     req = '0;
   logic [N-1:0]     pix_valid = '0;
   logic [N-1:0]     done = '0;
   logic [8*N-1:0]   x_in = '0;
   logic [7*N-1:0]   y_in = '0;
   logic [3*N-1:0]   col_in = '0;
   logic [N-1:0]     gnt;
   logic             draw_enable;
   logic [7:0]       x_out;
   logic [6:0]       y_out;
   logic [2:0]       col_out;
   logic             busy;
   logic             stall_err;

   int               checks = 0;
   int               errors = 0;
   logic [17:0]      pix_q[$];
   int               gnt_q[$];
   logic [N-1:0]     prev_gnt = '0;
   bit               saw99 = 1'b0;
   logic [17:0]      mon_exp;
   int               mon_g;
   int               lat;
   int               cnt;

   draw_port_arbiter #(
      .N         (N),
      .PTR_W     (PTR_W),
      .MAX_STALL (MAX_STALL),
      .STALL_W   (STALL_W)
   ) dut (
      .clk         (clk),
      .resetn      (resetn),
      .req         (req),
      .pix_valid   (pix_valid),
      .done        (done),
      .x_in        (x_in),
      .y_in        (y_in),
      .col_in      (col_in),
      .gnt         (gnt),
      .draw_enable (draw_enable),
      .x_out       (x_out),
      .y_out       (y_out),
      .col_out     (col_out),
      .busy        (busy),
      .stall_err   (stall_err)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d (0x%0h), required %0d (0x%0h)", name, act, act, exp, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input int i, input bit v, input bit d, input logic [7:0] x,
                        input logic [6:0] y, input logic [2:0] c, input bit expect_out);
      pix_valid[i]      = v;
      done[i]           = d;
      x_in[i*8 +: 8]    = x;
      y_in[i*7 +: 7]    = y;
      col_in[i*3 +: 3]  = c;
      if (v && expect_out) pix_q.push_back({x, y, c});
   endtask

   task automatic wait_gnt(input int i, output int l);
      l = 0;
      do begin
         tick;
         l++;
      end while (!gnt[i] && l < 64);
      if (!gnt[i]) begin
         checks++;
         errors++;
         $display("FAIL wait_gnt%0d: no grant after %0d cycles, gnt=%b", i, l, gnt);
      end
   endtask

   task automatic burst(input int i, input int n, input logic [7:0] x0, input logic [6:0] y0,
                        input logic [2:0] c0, input bit drop);
      for (int p = 0; p < n; p++) begin
         drive(i, 1'b1, (p == n - 1), x0 + 8'(p), y0, c0, 1'b1);
         tick;
      end
      drive(i, 1'b0, 1'b0, x0, y0, c0, 1'b0);
      if (drop) req[i] = 1'b0;
      check($sformatf("release_gnt%0d", i), 32'(gnt), 32'd0);
      check($sformatf("release_busy%0d", i), 32'(busy), 32'd1);
   endtask

   always @(negedge clk) begin
      if (resetn) begin
         if (draw_enable) begin
            if (x_out == 8'd99) saw99 = 1'b1;
            if (pix_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL pixel_unexpected: got x=%0d y=%0d c=%0d, required no pixel",
                        x_out, y_out, col_out);
            end else begin
               mon_exp = pix_q.pop_front();
               check("pixel_xyc", 32'({x_out, y_out, col_out}), 32'(mon_exp));
            end
         end
         if (gnt != '0 && prev_gnt == '0) begin
            if (gnt_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL grant_unexpected: got gnt=%b, required none", gnt);
            end else begin
               mon_g = gnt_q.pop_front();
               check("grant_order", 32'(gnt), 32'(1) << mon_g);
            end
         end
      end
      prev_gnt = gnt;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "time limit");
   end

   initial begin
      // Reset and idle
      repeat (3) begin
         tick;
         check("reset_outs", 32'({gnt, draw_enable, x_out, y_out, col_out, busy, stall_err}), 32'd0);
      end
      resetn = 1'b1;
      repeat (20) begin
         tick;
         check("idle_outs", 32'({gnt, draw_enable, x_out, y_out, col_out, busy, stall_err}), 32'd0);
      end

      // Single burst from requester 1
      gnt_q.push_back(1);
      req[1] = 1'b1;
      wait_gnt(1, lat);
      check("req_gnt_latency", 32'(lat), 32'd1);
      check("gnt_single", 32'(gnt), 32'b0010);
      check("busy_grant", 32'(busy), 32'd1);
      burst(1, 3, 8'd10, 7'd5, 3'd3, 1'b1);
      tick;
      check("idle_after_release", 32'({gnt, draw_enable, busy}), 32'd0);

      // Pointer now 2: requesters 0 and 1 together grant 0 first
      gnt_q.push_back(0);
      gnt_q.push_back(1);
      req = 4'b0011;
      wait_gnt(0, lat);
      check("ptr_after_burst", 32'(gnt), 32'b0001);
      burst(0, 1, 8'd20, 7'd6, 3'd1, 1'b1);
      wait_gnt(1, lat);
      burst(1, 1, 8'd21, 7'd6, 3'd2, 1'b1);
      tick;
      tick;

      // Round robin from a fresh pointer
      resetn = 1'b0;
      tick;
      tick;
      resetn = 1'b1;
      for (int b = 0; b < 5; b++) gnt_q.push_back(b % 4);
      req = 4'b1111;
      for (int b = 0; b < 5; b++) begin
         wait_gnt(b % 4, lat);
         check("rr_latency", 32'(lat), (b == 0) ? 32'd1 : 32'd2);
         burst(b % 4, 2, 8'(30 + 10 * b), 7'(b), 3'(b), 1'b0);
         if (b == 4) req = '0;
      end
      tick;
      tick;

      // Isolation: requester 0 drives pixels and done while 2 owns the port
      gnt_q.push_back(2);
      req[2] = 1'b1;
      wait_gnt(2, lat);
      drive(2, 1'b1, 1'b0, 8'd40, 7'd9, 3'd5, 1'b1);
      drive(0, 1'b1, 1'b1, 8'd99, 7'd99, 3'd7, 1'b0);
      tick;
      drive(2, 1'b0, 1'b0, 8'd40, 7'd9, 3'd5, 1'b0);
      tick;
      check("iso_de_low", 32'(draw_enable), 32'd0);
      check("iso_still_owner", 32'(gnt), 32'b0100);
      drive(2, 1'b1, 1'b1, 8'd41, 7'd9, 3'd5, 1'b1);
      tick;
      drive(2, 1'b0, 1'b0, 8'd0, 7'd0, 3'd0, 1'b0);
      drive(0, 1'b0, 1'b0, 8'd0, 7'd0, 3'd0, 1'b0);
      req[2] = 1'b0;
      check("iso_release", 32'(gnt), 32'd0);
      tick;
      tick;
      check("iso_no_99", 32'(saw99), 32'd0);

      // Abandoned burst: pointer 3 scans to requester 1
      gnt_q.push_back(1);
      req[1] = 1'b1;
      wait_gnt(1, lat);
      tick;
      req[1] = 1'b0;
      tick;
      check("abandon_release", 32'(gnt), 32'd0);
      check("abandon_no_err", 32'(stall_err), 32'd0);
      tick;
      tick;

      // Stall watchdog on requester 3
      gnt_q.push_back(3);
      req[3] = 1'b1;
      wait_gnt(3, lat);
      cnt = 1;
      while (gnt[3] && cnt <= MAX_STALL + 50) begin
         tick;
         if (gnt[3]) cnt++;
      end
      check("stall_len", 32'(cnt), 32'(MAX_STALL));
      check("stall_err_set", 32'(stall_err), 32'd1);
      check("stall_busy_release", 32'(busy), 32'd1);
      req[3] = 1'b0;
      tick;
      tick;
      gnt_q.push_back(0);
      req[0] = 1'b1;
      wait_gnt(0, lat);
      burst(0, 2, 8'd50, 7'd10, 3'd6, 1'b1);
      tick;
      tick;
      check("stall_err_sticky", 32'(stall_err), 32'd1);

      // Asynchronous reset in the middle of a burst
      gnt_q.push_back(2);
      req[2] = 1'b1;
      wait_gnt(2, lat);
      drive(2, 1'b1, 1'b0, 8'd60, 7'd11, 3'd4, 1'b1);
      tick;
      drive(2, 1'b0, 1'b0, 8'd0, 7'd0, 3'd0, 1'b0);
      check("mid_de_before", 32'(draw_enable), 32'd1);
      #2;
      resetn = 1'b0;
      #1;
      check("mid_async_outs", 32'({gnt, draw_enable, busy}), 32'd0);
      check("mid_stall_err_clr", 32'(stall_err), 32'd0);
      pix_q.delete();
      req = 4'b0101;
      tick;
      tick;
      resetn = 1'b1;
      gnt_q.push_back(0);
      gnt_q.push_back(2);
      wait_gnt(0, lat);
      check("post_reset_gnt", 32'(gnt), 32'b0001);
      burst(0, 1, 8'd70, 7'd12, 3'd1, 1'b1);
      wait_gnt(2, lat);
      burst(2, 1, 8'd71, 7'd12, 3'd2, 1'b1);
      tick;
      tick;

      check("pix_q_empty", 32'(pix_q.size()), 32'd0);
      check("gnt_q_empty", 32'(gnt_q.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
